// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg -- shared types and constants for the fetch PC generator.
//   pc_sel_e    : which source drives the next fetch PC
//   pcg_state_e : generator state (BOOT after reset, RUN while fetching)
//   INSTR_BYTES : sequential fetch stride in bytes
// ---------------------------------------------------------------------------
package pc_pkg;

   typedef enum logic [1:0] {
      SEL_SEQ,
      SEL_BR,
      SEL_JALR,
      SEL_TRAP
   } pc_sel_e;

   typedef enum logic {
      BOOT,
      RUN
   } pcg_state_e;

   localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/pc_target_sel.sv
// ---------------------------------------------------------------------------
// pc_target_sel -- combinational redirect source selection.
// Priority trap > jalr > branch. Computes the target address and flags a
// misaligned jalr/branch target. The trap vector is never alignment-checked.
// Ports:
//   i_trap, i_jalr, i_br_taken : redirect requests
//   i_trap_vec                 : trap handler address
//   i_rs1, i_imm               : JALR base and shared immediate
//   i_br_base                  : PC of the branch/JAL instruction
//   o_sel                      : selected source (SEL_SEQ when no request)
//   o_target                   : raw selected target (wraps mod 2^XLEN)
//   o_misaligned               : selected jalr/branch target is misaligned
// ---------------------------------------------------------------------------
module pc_target_sel
   import pc_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter bit C_EXT = 1'b0
) (
   input  logic            i_trap,
   input  logic            i_jalr,
   input  logic            i_br_taken,
   input  logic [XLEN-1:0] i_trap_vec,
   input  logic [XLEN-1:0] i_rs1,
   input  logic [XLEN-1:0] i_imm,
   input  logic [XLEN-1:0] i_br_base,
   output pc_sel_e         o_sel,
   output logic [XLEN-1:0] o_target,
   output logic            o_misaligned
);

   logic [XLEN-1:0] w_jalr_tgt;
   logic [XLEN-1:0] w_br_tgt;

   // JALR always clears bit 0 of the sum, so only bit 1 can be misaligned.
   assign w_jalr_tgt = (i_rs1 + i_imm) & ~XLEN'(1);
   assign w_br_tgt   = i_br_base + i_imm;

   always_comb begin
      // NOTE: every output gets a default before the priority chain, so no
      // path leaves a signal unassigned and no latch is inferred.
      o_sel        = SEL_SEQ;
      o_target     = '0;
      o_misaligned = 1'b0;
      if (i_trap) begin
         o_sel    = SEL_TRAP;
         o_target = i_trap_vec;
      end else if (i_jalr) begin
         o_sel        = SEL_JALR;
         o_target     = w_jalr_tgt;
         o_misaligned = !C_EXT && w_jalr_tgt[1];
      end else if (i_br_taken) begin
         o_sel        = SEL_BR;
         o_target     = w_br_tgt;
         o_misaligned = w_br_tgt[0] || (!C_EXT && w_br_tgt[1]);
      end
   end

endmodule

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen -- fetch program-counter generator.
// Holds the fetch PC, offers it to instruction memory with valid/ready,
// advances by INSTR_BYTES on an accepted, unstalled fetch and applies
// prioritised redirects. Misaligned redirect targets divert to trap_vec.
// Ports:
//   clk, rst          : clock; synchronous active-high reset
//   stall             : holds sequential advance (redirects still apply)
//   br_taken, br_base : branch/JAL redirect and its instruction PC
//   imm               : sign-extended immediate (branch and JALR)
//   jalr, rs1         : JALR redirect and base register value
//   trap, trap_vec    : trap redirect and handler address
//   fetch_valid/ready : fetch handshake; fetch_pc is the request address
//   pc_plus4          : fetch_pc + 4 (combinational, wraps)
//   redirect          : one-cycle pulse after a redirect edge
//   misalign          : one-cycle pulse after a misaligned redirect
//   bad_addr          : last misaligned target
// ---------------------------------------------------------------------------
module pc_gen
   import pc_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = '0,
   parameter bit              C_EXT     = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            br_taken,
   input  logic [XLEN-1:0] br_base,
   input  logic [XLEN-1:0] imm,
   input  logic            jalr,
   input  logic [XLEN-1:0] rs1,
   input  logic            trap,
   input  logic [XLEN-1:0] trap_vec,
   output logic            fetch_valid,
   input  logic            fetch_ready,
   output logic [XLEN-1:0] fetch_pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            redirect,
   output logic            misalign,
   output logic [XLEN-1:0] bad_addr
);

   pcg_state_e      r_state;
   pcg_state_e      w_state_next;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_pc_next;
   logic            r_redirect;
   logic            r_misalign;
   logic [XLEN-1:0] r_bad_addr;
   pc_sel_e         w_sel;
   logic [XLEN-1:0] w_target;
   logic            w_misaligned;
   logic            w_redirect_take;
   logic            w_advance;

   pc_target_sel #(
      .XLEN (XLEN),
      .C_EXT(C_EXT)
   ) u_target_sel (
      .i_trap      (trap),
      .i_jalr      (jalr),
      .i_br_taken  (br_taken),
      .i_trap_vec  (trap_vec),
      .i_rs1       (rs1),
      .i_imm       (imm),
      .i_br_base   (br_base),
      .o_sel       (w_sel),
      .o_target    (w_target),
      .o_misaligned(w_misaligned)
   );

   assign fetch_pc = r_pc;
   assign pc_plus4 = r_pc + XLEN'(INSTR_BYTES);
   assign redirect = r_redirect;
   assign misalign = r_misalign;
   assign bad_addr = r_bad_addr;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      if (rst) r_state <= BOOT;
      else     r_state <= w_state_next;
   end

   // Next state and handshake outputs. BOOT is a single dead cycle; nothing
   // is requested and no redirect or advance is honoured there.
   always_comb begin
      w_state_next    = r_state;
      fetch_valid     = 1'b0;
      w_redirect_take = 1'b0;
      w_advance       = 1'b0;
      case (r_state)
         BOOT: w_state_next = RUN;
         RUN: begin
            fetch_valid     = 1'b1;
            w_redirect_take = (w_sel != SEL_SEQ);
            // A redirect overrides the handshake; a fetch accepted in the
            // same cycle is flushed by the front end via redirect.
            w_advance       = !w_redirect_take && fetch_ready && !stall;
         end
         default: w_state_next = BOOT;
      endcase
   end

   always_comb begin
      w_pc_next = r_pc;
      if (w_redirect_take) w_pc_next = w_misaligned ? trap_vec : w_target;
      else if (w_advance)  w_pc_next = pc_plus4;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc       <= RESET_VEC;
         r_redirect <= 1'b0;
         r_misalign <= 1'b0;
         r_bad_addr <= '0;
      end else begin
         r_pc       <= w_pc_next;
         r_redirect <= w_redirect_take;
         r_misalign <= w_redirect_take && w_misaligned;
         if (w_redirect_take && w_misaligned) r_bad_addr <= w_target;
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen -- table-driven bench for pc_gen. Two instances share stimulus:
// dut0 with C_EXT=0 and dut1 with C_EXT=1, both with RESET_VEC=0x1000.
// Each table row is one clock of inputs plus the outputs expected after
// that edge; expectations are queued on drive and popped after the edge.
// ---------------------------------------------------------------------------
module tb_pc_gen;

   localparam int          XLEN = 32;
   localparam logic [31:0] RV   = 32'h0000_1000;
   localparam logic [31:0] TV   = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst, stall, br_taken, jalr, trap, fetch_ready;
   logic [31:0] br_base, imm, rs1, trap_vec;

   logic        v0, red0, mis0, v1, red1, mis1;
   logic [31:0] pc0, p40, bad0, pc1, p41, bad1;

   always #5 clk = ~clk;

   pc_gen #(.XLEN(XLEN), .RESET_VEC(RV), .C_EXT(1'b0)) dut0 (
      .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken),
      .br_base(br_base), .imm(imm), .jalr(jalr), .rs1(rs1), .trap(trap),
      .trap_vec(trap_vec), .fetch_valid(v0), .fetch_ready(fetch_ready),
      .fetch_pc(pc0), .pc_plus4(p40), .redirect(red0), .misalign(mis0),
      .bad_addr(bad0)
   );

   pc_gen #(.XLEN(XLEN), .RESET_VEC(RV), .C_EXT(1'b1)) dut1 (
      .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken),
      .br_base(br_base), .imm(imm), .jalr(jalr), .rs1(rs1), .trap(trap),
      .trap_vec(trap_vec), .fetch_valid(v1), .fetch_ready(fetch_ready),
      .fetch_pc(pc1), .pc_plus4(p41), .redirect(red1), .misalign(mis1),
      .bad_addr(bad1)
   );

   typedef struct {
      logic        rst, stall, rdy, trap, jalr, br;
      logic [31:0] br_base, imm, rs1;
      logic        valid, red;
      logic [31:0] pc0;
      logic        mis0;
      logic [31:0] bad0, pc1;
      logic        mis1;
      logic [31:0] bad1;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   n_vec  = 0;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cur    = 0;

   function automatic vec_t v(input logic r, s, rd, t, j, b,
                              input logic [31:0] bb, im, r1,
                              input logic val, rdr, input logic [31:0] p0,
                              input logic m0, input logic [31:0] b0, p1,
                              input logic m1, input logic [31:0] b1);
      vec_t x;
      x.rst = r; x.stall = s; x.rdy = rd; x.trap = t; x.jalr = j; x.br = b;
      x.br_base = bb; x.imm = im; x.rs1 = r1;
      x.valid = val; x.red = rdr; x.pc0 = p0; x.mis0 = m0; x.bad0 = b0;
      x.pc1 = p1; x.mis1 = m1; x.bad1 = b1;
      return x;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL vec %0d %s: got %h expected %h", cur, name, act, exp);
      end
   endtask

   initial begin
      // rst stall rdy trap jalr br | br_base imm rs1 | valid red pc0 mis0 bad0 | pc1 mis1 bad1
      // Reset: two cycles high, then one BOOT cycle before fetching 0x1000.
      tbl.push_back(v(1,0,1,0,0,0, 0,0,0, 0,0,32'h1000,0,0, 32'h1000,0,0));
      tbl.push_back(v(1,0,1,0,0,0, 0,0,0, 0,0,32'h1000,0,0, 32'h1000,0,0));
      tbl.push_back(v(0,0,1,0,0,0, 0,0,0, 1,0,32'h1000,0,0, 32'h1000,0,0));
      tbl.push_back(v(0,0,1,0,0,0, 0,0,0, 1,0,32'h1004,0,0, 32'h1004,0,0));
      tbl.push_back(v(0,0,1,0,0,0, 0,0,0, 1,0,32'h1008,0,0, 32'h1008,0,0));
      // Branch to 0x2000, then back-pressure for three cycles, then accept.
      tbl.push_back(v(0,0,0,0,0,1, 32'h2000,0,0, 1,1,32'h2000,0,0, 32'h2000,0,0));
      for (int i = 0; i < 3; i++)
         tbl.push_back(v(0,0,0,0,0,0, 0,0,0, 1,0,32'h2000,0,0, 32'h2000,0,0));
      tbl.push_back(v(0,0,1,0,0,0, 0,0,0, 1,0,32'h2004,0,0, 32'h2004,0,0));
      // Stall with ready high holds as well.
      tbl.push_back(v(0,1,1,0,0,0, 0,0,0, 1,0,32'h2004,0,0, 32'h2004,0,0));
      tbl.push_back(v(0,1,1,0,0,0, 0,0,0, 1,0,32'h2004,0,0, 32'h2004,0,0));
      tbl.push_back(v(0,0,1,0,0,0, 0,0,0, 1,0,32'h2008,0,0, 32'h2008,0,0));
      // Priority: trap wins over jalr+br; then jalr wins over br.
      tbl.push_back(v(0,0,1,1,1,1, 32'h500,8,32'h3000, 1,1,32'h0100,0,0, 32'h0100,0,0));
      tbl.push_back(v(0,0,1,0,1,1, 32'h500,8,32'h3000, 1,1,32'h3008,0,0, 32'h3008,0,0));
      tbl.push_back(v(0,0,0,0,0,0, 0,0,0, 1,0,32'h3008,0,0, 32'h3008,0,0));
      // JALR bit 0 is cleared, not a misalignment.
      tbl.push_back(v(0,0,0,0,1,0, 0,0,32'h4001, 1,1,32'h4000,0,0, 32'h4000,0,0));
      // Branch to 0x502: misaligned without C, legal with C.
      tbl.push_back(v(0,0,0,0,0,1, 32'h500,2,0, 1,1,32'h0100,1,32'h502, 32'h0502,0,0));
      tbl.push_back(v(0,0,0,0,0,0, 0,0,0, 1,0,32'h0100,0,32'h502, 32'h0502,0,0));
      // Wrap-around: sequential from 0xFFFF_FFFC, then branch sum wraps.
      tbl.push_back(v(0,0,0,0,0,1, 32'hFFFF_FFFC,0,0, 1,1,32'hFFFF_FFFC,0,32'h502, 32'hFFFF_FFFC,0,0));
      tbl.push_back(v(0,0,1,0,0,0, 0,0,0, 1,0,32'h0,0,32'h502, 32'h0,0,0));
      tbl.push_back(v(0,0,0,0,0,1, 32'hFFFF_FFF0,32'h20,0, 1,1,32'h10,0,32'h502, 32'h10,0,0));
      // Odd branch target is misaligned even with C.
      tbl.push_back(v(0,0,0,0,0,1, 32'h600,1,0, 1,1,32'h0100,1,32'h601, 32'h0100,1,32'h601));
      // JALR target with bit 1 set: trap without C, legal with C.
      tbl.push_back(v(0,0,0,0,1,0, 0,0,32'h702, 1,1,32'h0100,1,32'h702, 32'h0702,0,32'h601));
      // Reset during the redirect cycle, with a new request pending.
      tbl.push_back(v(1,0,1,0,0,1, 32'h800,0,0, 0,0,32'h1000,0,0, 32'h1000,0,0));
      tbl.push_back(v(0,0,1,0,0,0, 0,0,0, 1,0,32'h1000,0,0, 32'h1000,0,0));
      tbl.push_back(v(0,0,1,0,0,0, 0,0,0, 1,0,32'h1004,0,0, 32'h1004,0,0));
      tbl.push_back(v(0,1,1,0,0,0, 0,0,0, 1,0,32'h1004,0,0, 32'h1004,0,0));
      // Reset during stall.
      tbl.push_back(v(1,1,1,0,0,0, 0,0,0, 0,0,32'h1000,0,0, 32'h1000,0,0));
      // Redirect requests in BOOT are ignored.
      tbl.push_back(v(0,0,1,1,0,1, 32'h900,0,0, 1,0,32'h1000,0,0, 32'h1000,0,0));
      tbl.push_back(v(0,0,1,0,0,0, 0,0,0, 1,0,32'h1004,0,0, 32'h1004,0,0));

      trap_vec = TV;
      rst = 1'b1; stall = 1'b0; fetch_ready = 1'b0;
      trap = 1'b0; jalr = 1'b0; br_taken = 1'b0;
      br_base = '0; imm = '0; rs1 = '0;
      @(negedge clk);

      foreach (tbl[k]) begin
         vec_t e;
         rst = tbl[k].rst; stall = tbl[k].stall; fetch_ready = tbl[k].rdy;
         trap = tbl[k].trap; jalr = tbl[k].jalr; br_taken = tbl[k].br;
         br_base = tbl[k].br_base; imm = tbl[k].imm; rs1 = tbl[k].rs1;
         exp_q.push_back(tbl[k]);
         n_vec++;
         @(posedge clk);
         #1;
         e   = exp_q.pop_front();
         cur = k;
         check("valid0",    32'(v0),   32'(e.valid));
         check("fetch_pc0", pc0,       e.pc0);
         check("pc_plus4_0", p40,      e.pc0 + 32'd4);
         check("redirect0", 32'(red0), 32'(e.red));
         check("misalign0", 32'(mis0), 32'(e.mis0));
         check("bad_addr0", bad0,      e.bad0);
         check("valid1",    32'(v1),   32'(e.valid));
         check("fetch_pc1", pc1,       e.pc1);
         check("redirect1", 32'(red1), 32'(e.red));
         check("misalign1", 32'(mis1), 32'(e.mis1));
         check("bad_addr1", bad1,      e.bad1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
